// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat carrying one instruction word with its PC, PC+4 and jump flag.
// The master drives the beat and the slave returns ready.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] instn;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pcplus4;
    logic              jump;

    modport master (
        output valid, instn, pc, pcplus4, jump,
        input  ready
    );

    modport slave (
        input  valid, instn, pc, pcplus4, jump,
        output ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register for the instruction path, clocked on the falling edge.
// Optional stall counter compiled in with `define PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int JADDR_W = 26,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    pipe_stage_reg_if.slave     up,
    pipe_stage_reg_if.master    dn,
    output logic [JADDR_W-1:0]  jump_address
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt
`endif
);

    if (JADDR_W > DATA_W || JADDR_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_stage_reg: JADDR_W must be 1..DATA_W and CNT_W at least 1");
    end

    typedef struct packed {
        logic [DATA_W-1:0] instn;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pcplus4;
        logic              jump;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    beat_t  main_p0;
    beat_t  skid_p1;
    beat_t  in_beat;
    logic   in_fire;
    logic   out_fire;

    assign in_beat = '{instn:   up.instn,
                       pc:      up.pc,
                       pcplus4: up.pcplus4,
                       jump:    up.jump};

    assign up.ready = (state != FULL);
    assign dn.valid = (state != EMPTY);

    assign in_fire  = up.valid & up.ready;
    assign out_fire = dn.valid & dn.ready;

    // Input stage: main_p0 is always the oldest beat, skid_p1 the one behind it.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            main_p0 <= '0;
            skid_p1 <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_p0 <= in_beat;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_p0 <= in_beat;
                    end else if (in_fire) begin
                        skid_p1 <= in_beat;
                        state   <= FULL;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_p0 <= skid_p1;
                        state   <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Output stage: everything downstream sees comes straight from main_p0.
    assign dn.instn     = main_p0.instn;
    assign dn.pc        = main_p0.pc;
    assign dn.pcplus4   = main_p0.pcplus4;
    assign dn.jump      = main_p0.jump;
    assign jump_address = main_p0.instn[JADDR_W-1:0];

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (dn.valid && !dn.ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue model of the two-entry FIFO checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [31:0] instn;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        jump;
    } beat_t;

    logic        clk = 1'b1;
    logic        rst_n;
    logic        flush;
    logic [25:0] jump_address;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    beat_t q[$];
    int    m_stall = 0;

    pipe_stage_reg_if #(.DATA_W(32), .PC_W(32)) up_if ();
    pipe_stage_reg_if #(.DATA_W(32), .PC_W(32)) dn_if ();

    pipe_stage_reg #(
        .DATA_W (32),
        .PC_W   (32),
        .JADDR_W(26),
        .CNT_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .flush       (flush),
        .up          (up_if),
        .dn          (dn_if),
        .jump_address(jump_address)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(input logic [31:0] ins);
        beat_t b;
        b.instn   = ins;
        b.pc      = ins + 32'h0000_0100;
        b.pcplus4 = ins + 32'h0000_0104;
        b.jump    = ins[4];
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two beats; consume first, then flush or accept.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_stall = 0;
        end else begin
            bit m_in, m_out;
            m_in  = up_if.valid && (q.size() < 2);
            m_out = (q.size() > 0) && dn_if.ready;
            if (q.size() > 0 && !dn_if.ready && m_stall < 15) m_stall++;
            if (m_out) void'(q.pop_front());
            if (flush) q.delete();
            else if (m_in) q.push_back(mk(up_if.instn));
        end
    end

    always @(posedge clk) begin
        chk("out_valid", dn_if.valid, q.size() != 0);
        chk("in_ready", up_if.ready, q.size() < 2);
        if (q.size() != 0) begin
            chk("out_instn", dn_if.instn, q[0].instn);
            chk("out_pc", dn_if.pc, q[0].pc);
            chk("out_pcplus4", dn_if.pcplus4, q[0].pcplus4);
            chk("out_jump", dn_if.jump, q[0].jump);
            chk("jump_address", jump_address, q[0].instn[25:0]);
        end
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic r, input logic f);
        beat_t b;
        b = mk(ins);
        up_if.valid   = v;
        up_if.instn   = b.instn;
        up_if.pc      = b.pc;
        up_if.pcplus4 = b.pcplus4;
        up_if.jump    = b.jump;
        dn_if.ready   = r;
        flush         = f;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [1:0] pat [16] = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11,
                             2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11};

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        up_if.valid   = 1'b0;
        up_if.instn   = '0;
        up_if.pc      = '0;
        up_if.pcplus4 = '0;
        up_if.jump    = 1'b0;
        dn_if.ready   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", dn_if.valid, 1'b0);
        chk("rst_in_ready", up_if.ready, 1'b1);
        chk("rst_out_instn", dn_if.instn, 32'h0);
        chk("rst_jump_address", jump_address, 26'h0);
`ifdef PIPE_STAGE_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 4'h0);
`endif
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Streaming
        drive(1, 32'h0800_0010, 1, 0);
        chk("stream0_instn", dn_if.instn, 32'h0800_0010);
        chk("stream0_jaddr", jump_address, 26'h000_0010);
        drive(1, 32'h0800_0020, 1, 0);
        chk("stream1_instn", dn_if.instn, 32'h0800_0020);
        chk("stream1_jaddr", jump_address, 26'h000_0020);
        chk("stream1_ready", up_if.ready, 1'b1);
        drive(1, 32'h0800_0030, 1, 0);
        chk("stream2_instn", dn_if.instn, 32'h0800_0030);
        chk("stream2_jaddr", jump_address, 26'h000_0030);
        chk("stream2_pc", dn_if.pc, 32'h0800_0130);
        drive(0, 32'h0, 1, 0);
        chk("stream_drained", dn_if.valid, 1'b0);

        // Backpressure
        drive(1, 32'h0000_00A0, 0, 0);
        drive(1, 32'h0000_00B0, 0, 0);
        chk("bp_full_ready", up_if.ready, 1'b0);
        chk("bp_full_instn", dn_if.instn, 32'h0000_00A0);
        drive(0, 32'h0, 0, 0);
        chk("bp_hold_instn", dn_if.instn, 32'h0000_00A0);
        dn_if.ready = 1'b1;
        #1;
        chk("bp_a_first", dn_if.instn, 32'h0000_00A0);
        drive(0, 32'h0, 1, 0);
        chk("bp_b_second", dn_if.instn, 32'h0000_00B0);
        chk("bp_b_valid", dn_if.valid, 1'b1);
        drive(0, 32'h0, 1, 0);
        chk("bp_empty", dn_if.valid, 1'b0);

        // Flush in FULL with a beat on the input
        drive(1, 32'h0000_00D0, 0, 0);
        drive(1, 32'h0000_00E0, 0, 0);
        drive(1, 32'h0000_00C0, 0, 1);
        chk("flush_full_valid", dn_if.valid, 1'b0);
        chk("flush_full_ready", up_if.ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 1, 0);
            chk("flush_no_c", dn_if.valid, 1'b0);
        end

        // Flush in ONE with an accepted beat and a consumed beat
        drive(1, 32'h0000_00D4, 0, 0);
        drive(1, 32'h0000_00C4, 1, 1);
        chk("flush_one_valid", dn_if.valid, 1'b0);
        drive(0, 32'h0, 1, 0);
        chk("flush_one_no_c", dn_if.valid, 1'b0);

        // Mixed valid/ready pattern
        for (int i = 0; i < 16; i++) begin
            drive(pat[i][1], 32'h0400_0000 + 32'(i * 16), pat[i][0], 0);
        end
        drive(0, 32'h0, 1, 0);
        drive(0, 32'h0, 1, 0);
        chk("mix_drained", dn_if.valid, 1'b0);

        // Asynchronous reset between edges while holding one beat
        drive(1, 32'h0800_00F0, 0, 0);
        chk("arst_pre_valid", dn_if.valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", dn_if.valid, 1'b0);
        chk("arst_instn", dn_if.instn, 32'h0);
        chk("arst_ready", up_if.ready, 1'b1);
        chk("arst_jaddr", jump_address, 26'h0);
        #1 rst_n = 1'b1;
        drive(1, 32'h0800_0123, 1, 0);
        chk("post_rst_first", dn_if.instn, 32'h0800_0123);
        chk("post_rst_jaddr", jump_address, 26'h000_0123);
        drive(0, 32'h0, 1, 0);

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter saturation
        drive(1, 32'h0000_0111, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 32'h0, 0, 0);
        chk("stall_sat", stall_cnt, 4'hF);
        drive(0, 32'h0, 0, 1);
        chk("stall_after_flush", stall_cnt, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("stall_reset", stall_cnt, 4'h0);
        #1 rst_n = 1'b1;
        drive(0, 32'h0, 1, 0);
`endif

        drive(0, 32'h0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
